trig_seq: RTL and testbench

- Multi-channel, multi-stage trigger engine for the logic-analyser capture path.
- Each channel is qualified per stage as don't-care, level (low/high) or edge (rising/falling); a stage matches when every channel qualifier holds.
- A sequencer steps through up to STAGES stages, each needing a programmable number of match cycles, and raises a sticky trigger to the capture controller on completion.

---
 rtl/trig_seq.sv | 164 ++++++++++++++++
 tb/tb_trig_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/trig_seq.sv
// Multi-stage trigger sequencer for the logic-analyser capture path.
// Per-channel level/edge qualifiers feed a stage matcher that a small FSM steps through.
module trig_seq #(
  parameter int CH_NUM = 8,
  parameter int STAGES = 4,
  parameter int CNT_W  = 8,
  parameter int CH_W   = 3,
  parameter int ST_W   = 2
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              EN,
  input  logic [CH_NUM-1:0] Xin,
  input  logic              wEN,
  input  logic              wCntEN,
  input  logic [ST_W-1:0]   wSTAGE,
  input  logic [CH_W-1:0]   wCH,
  input  logic [3:0]        wCMD,
  input  logic [CNT_W-1:0]  wCNT,
  input  logic              SetInit,
  output logic              ResTri,
  output logic [ST_W-1:0]   Stage,
  output logic              Armed
);

  typedef enum logic [1:0] {IDLE, ARMED, TRIGGERED} state_t;

  state_t             state_reg;
  logic [ST_W-1:0]    stage_reg;
  logic [CNT_W-1:0]   hits_reg;
  logic               res_tri_reg;
  logic               armed_reg;

  logic [CH_NUM-1:0]  x_new_reg;
  logic [CH_NUM-1:0]  x_old_reg;

  // Qualifier kept as {enable, pattern[1:0]}; wCMD[2] carries no meaning.
  logic [2:0]         qual_reg [STAGES][CH_NUM];
  logic [CNT_W-1:0]   cnt_reg  [STAGES];

  logic [STAGES-1:0]  stage_hit;
  logic               cur_hit;
  logic [CNT_W-1:0]   cur_cnt;
  logic [CNT_W-1:0]   cur_need;
  logic [CNT_W:0]     hits_inc;
  logic               need_more;
  logic               cmd_unused;

  assign cmd_unused = wCMD[2];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      x_new_reg <= '0;
      x_old_reg <= '0;
    end else begin
      x_new_reg <= Xin;
      x_old_reg <= x_new_reg;
    end
  end

  // Out-of-range stage/channel selects match no entry, so such writes drop out.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int s = 0; s < STAGES; s++) begin
        cnt_reg[s] <= '0;
        for (int c = 0; c < CH_NUM; c++) qual_reg[s][c] <= '0;
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (wCntEN && (wSTAGE == ST_W'(s))) cnt_reg[s] <= wCNT;
        for (int c = 0; c < CH_NUM; c++) begin
          if (wEN && (wSTAGE == ST_W'(s)) && (wCH == CH_W'(c)))
            qual_reg[s][c] <= {wCMD[3], wCMD[1:0]};
        end
      end
    end
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic [CH_NUM-1:0] ch_hit;
      for (gj = 0; gj < CH_NUM; gj++) begin : g_ch
        assign ch_hit[gj] = !qual_reg[gi][gj][2] ||
                            ({x_old_reg[gj], x_new_reg[gj]} == qual_reg[gi][gj][1:0]);
      end
      assign stage_hit[gi] = &ch_hit;
    end
  endgenerate

  always_comb begin
    cur_hit = 1'b0;
    cur_cnt = '0;
    for (int s = 0; s < STAGES; s++) begin
      if (stage_reg == ST_W'(s)) begin
        cur_hit = stage_hit[s];
        cur_cnt = cnt_reg[s];
      end
    end
  end

  assign cur_need  = (cur_cnt == '0) ? CNT_W'(1) : cur_cnt;
  assign hits_inc  = {1'b0, hits_reg} + (CNT_W + 1)'(1);
  assign need_more = hits_inc < {1'b0, cur_need};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg   <= IDLE;
      stage_reg   <= '0;
      hits_reg    <= '0;
      res_tri_reg <= 1'b0;
      armed_reg   <= 1'b0;
    end else if (!EN) begin
      state_reg   <= IDLE;
      stage_reg   <= '0;
      hits_reg    <= '0;
      res_tri_reg <= 1'b0;
      armed_reg   <= 1'b0;
    end else if (SetInit && (state_reg != IDLE)) begin
      state_reg   <= ARMED;
      stage_reg   <= '0;
      hits_reg    <= '0;
      res_tri_reg <= 1'b0;
      armed_reg   <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          state_reg <= ARMED;
          armed_reg <= 1'b1;
        end
        ARMED: begin
          if (cur_hit) begin
            if (need_more) begin
              hits_reg <= hits_inc[CNT_W-1:0];
            end else if (stage_reg != ST_W'(STAGES - 1)) begin
              stage_reg <= stage_reg + ST_W'(1);
              hits_reg  <= '0;
            end else begin
              state_reg   <= TRIGGERED;
              res_tri_reg <= 1'b1;
              armed_reg   <= 1'b0;
            end
          end
        end
        TRIGGERED: begin
          res_tri_reg <= 1'b1;
          armed_reg   <= 1'b0;
        end
        default: begin
          state_reg   <= IDLE;
          stage_reg   <= '0;
          hits_reg    <= '0;
          res_tri_reg <= 1'b0;
          armed_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign ResTri = res_tri_reg;
  assign Stage  = stage_reg;
  assign Armed  = armed_reg;

endmodule

// File: tb/tb_trig_seq.sv
// Scoreboard bench for trig_seq: a cycle model queues expected outputs per edge.
// Wider select ports are used so out-of-range stage/channel writes can be driven.
module tb_trig_seq;
  localparam int CH_NUM = 8;
  localparam int STAGES = 4;
  localparam int CNT_W  = 8;
  localparam int CH_W   = 4;
  localparam int ST_W   = 3;

  logic              CLK = 1'b0;
  logic              nRST = 1'b1;
  logic              EN = 1'b0;
  logic [CH_NUM-1:0] Xin = '0;
  logic              wEN = 1'b0;
  logic              wCntEN = 1'b0;
  logic [ST_W-1:0]   wSTAGE = '0;
  logic [CH_W-1:0]   wCH = '0;
  logic [3:0]        wCMD = '0;
  logic [CNT_W-1:0]  wCNT = '0;
  logic              SetInit = 1'b0;
  logic              ResTri;
  logic [ST_W-1:0]   Stage;
  logic              Armed;

  trig_seq #(.CH_NUM(CH_NUM), .STAGES(STAGES), .CNT_W(CNT_W), .CH_W(CH_W), .ST_W(ST_W)) dut (
    .CLK(CLK), .nRST(nRST), .EN(EN), .Xin(Xin), .wEN(wEN), .wCntEN(wCntEN),
    .wSTAGE(wSTAGE), .wCH(wCH), .wCMD(wCMD), .wCNT(wCNT), .SetInit(SetInit),
    .ResTri(ResTri), .Stage(Stage), .Armed(Armed)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model state: 0 idle, 1 armed, 2 triggered
  int m_q [STAGES][CH_NUM];
  int m_cnt [STAGES];
  int m_xo [CH_NUM];
  int m_xn [CH_NUM];
  int m_st, m_stage, m_hits, m_tri;

  typedef struct { int res; int stg; int arm; } exp_t;
  exp_t exp_q[$];

  task automatic model_reset();
    for (int s = 0; s < STAGES; s++) begin
      m_cnt[s] = 0;
      for (int c = 0; c < CH_NUM; c++) m_q[s][c] = 0;
    end
    for (int c = 0; c < CH_NUM; c++) begin m_xo[c] = 0; m_xn[c] = 0; end
    m_st = 0; m_stage = 0; m_hits = 0; m_tri = 0;
  endtask

  function automatic bit m_match(int s);
    bit all_ok = 1'b1;
    for (int c = 0; c < CH_NUM; c++) begin
      if ((m_q[s][c] & 8) != 0) begin
        case (m_q[s][c] & 3)
          0: if (!(m_xo[c] == 0 && m_xn[c] == 0)) all_ok = 1'b0;
          3: if (!(m_xo[c] == 1 && m_xn[c] == 1)) all_ok = 1'b0;
          1: if (!(m_xo[c] == 0 && m_xn[c] == 1)) all_ok = 1'b0;
          default: if (!(m_xo[c] == 1 && m_xn[c] == 0)) all_ok = 1'b0;
        endcase
      end
    end
    return all_ok;
  endfunction

  task automatic model_step();
    bit hit;
    int need;
    hit = m_match(m_stage);
    need = (m_cnt[m_stage] == 0) ? 1 : m_cnt[m_stage];
    if (!EN) begin
      m_st = 0; m_stage = 0; m_hits = 0; m_tri = 0;
    end else if (SetInit && m_st != 0) begin
      m_st = 1; m_stage = 0; m_hits = 0; m_tri = 0;
    end else if (m_st == 0) begin
      m_st = 1;
    end else if (m_st == 1 && hit) begin
      if (m_hits + 1 < need) m_hits++;
      else if (m_stage < STAGES - 1) begin m_stage++; m_hits = 0; end
      else begin m_st = 2; m_tri = 1; end
    end
    if (wEN && int'(wSTAGE) < STAGES && int'(wCH) < CH_NUM) m_q[int'(wSTAGE)][int'(wCH)] = int'(wCMD);
    if (wCntEN && int'(wSTAGE) < STAGES) m_cnt[int'(wSTAGE)] = int'(wCNT);
    for (int c = 0; c < CH_NUM; c++) begin m_xo[c] = m_xn[c]; m_xn[c] = int'(Xin[c]); end
  endtask

  task automatic tick(input string tag);
    exp_t e;
    model_step();
    e.res = m_tri; e.stg = m_stage; e.arm = (m_st == 1) ? 1 : 0;
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    wEN = 1'b0; wCntEN = 1'b0; SetInit = 1'b0;
    e = exp_q.pop_front();
    check({tag, "_restri"}, ResTri, e.res);
    check({tag, "_stage"}, Stage, e.stg);
    check({tag, "_armed"}, Armed, e.arm);
  endtask

  task automatic wq(input int s, input int c, input int cmd);
    wEN = 1'b1; wSTAGE = s[ST_W-1:0]; wCH = c[CH_W-1:0]; wCMD = cmd[3:0];
  endtask

  task automatic wc(input int s, input int n);
    wCntEN = 1'b1; wSTAGE = s[ST_W-1:0]; wCNT = n[CNT_W-1:0];
  endtask

  task automatic run_seq(input string tag);
    Xin = 8'h02; repeat (2) tick(tag);
    Xin = 8'h03; repeat (3) tick(tag);
    Xin = 8'h02; repeat (3) tick(tag);
    check({tag, "_two_hits_stage"}, Stage, 0);
    Xin = 8'h03; repeat (2) tick(tag);
    Xin = 8'h02; repeat (3) tick(tag);
    check({tag, "_third_hit_stage"}, Stage, 1);
    check({tag, "_third_hit_tri"}, ResTri, 0);
    Xin = 8'h00; repeat (6) tick(tag);
    check({tag, "_fall_tri"}, ResTri, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_reset();
    #1 nRST = 1'b0;
    #1;
    check("rst_restri", ResTri, 0);
    check("rst_stage", Stage, 0);
    check("rst_armed", Armed, 0);
    @(posedge CLK); #1;
    nRST = 1'b1;

    // Default configuration: every stage passes in one cycle
    repeat (2) tick("idle");
    EN = 1'b1;
    tick("dflt");
    check("dflt_armed_after_en", Armed, 1);
    repeat (4) tick("dflt");
    check("dflt_tri", ResTri, 1);
    check("dflt_stage", Stage, 3);
    repeat (2) tick("dflt_hold");

    // Single rising-edge stage at the last stage; earlier stages pass through
    EN = 1'b0; tick("cfg");
    wq(3, 2, 4'b1001); wc(3, 1); tick("cfg");
    Xin = 8'h04; repeat (2) tick("cfg");
    EN = 1'b1; repeat (6) tick("rise_wait");
    check("rise_wait_stage", Stage, 3);
    check("rise_wait_tri", ResTri, 0);
    Xin = 8'h00; repeat (4) tick("fall_only");
    check("fall_only_tri", ResTri, 0);
    Xin = 8'h04; tick("rise_e1");
    check("rise_one_edge_tri", ResTri, 0);
    tick("rise_e2");
    check("rise_two_edge_tri", ResTri, 1);
    repeat (2) tick("rise_hold");

    // Level and edge stages with occurrence counts
    EN = 1'b0; tick("cfg2");
    wq(3, 2, 0); wc(3, 0); tick("cfg2");
    wq(0, 0, 4'b1011); wc(0, 3); tick("cfg2");
    wq(1, 1, 4'b1010); wc(1, 1); tick("cfg2");
    EN = 1'b1; tick("cfg2_arm");
    run_seq("seq");

    // Re-arm from TRIGGERED keeps the configuration
    SetInit = 1'b1; tick("setinit");
    check("setinit_tri", ResTri, 0);
    check("setinit_stage", Stage, 0);
    check("setinit_armed", Armed, 1);
    run_seq("reseq");

    // Mid-sequence write and disarm
    wq(1, 1, 4'b1011); wc(1, 4); tick("mid_cfg");
    SetInit = 1'b1; Xin = 8'h03; tick("mid_rearm");
    repeat (6) tick("mid_run");
    check("mid_stage", Stage, 1);
    check("mid_armed", Armed, 1);
    EN = 1'b0; tick("en_drop");
    check("en_drop_stage", Stage, 0);
    check("en_drop_armed", Armed, 0);
    check("en_drop_tri", ResTri, 0);
    EN = 1'b1; repeat (3) tick("rearm");

    // Asynchronous reset in the middle of a cycle
    #2 nRST = 1'b0;
    #1;
    check("async_rst_stage", Stage, 0);
    check("async_rst_armed", Armed, 0);
    check("async_rst_tri", ResTri, 0);
    model_reset();
    #1 nRST = 1'b1;
    EN = 1'b0;
    Xin = 8'hFF; repeat (2) tick("post_rst");

    // Out-of-range writes must leave the cleared configuration untouched
    wq(4, 0, 4'b1000); wc(4, 5); tick("oor");
    wq(0, 8, 4'b1000); tick("oor");
    wq(7, 15, 4'b1000); wc(7, 9); tick("oor");
    EN = 1'b1; tick("oor_run");
    check("oor_armed", Armed, 1);
    repeat (4) tick("oor_run");
    check("oor_tri", ResTri, 1);
    check("oor_stage", Stage, 3);

    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
